// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit.
// Turns the M-stage load/store control into one req/ack transaction on a
// multi-cycle data bus. It stalls the pipeline until the ack arrives, then
// returns the load data, sign- or zero-extended, to the MEM/WB path.
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   ResultSrcM      2'b01 marks a load
//   MemWriteM       store (takes priority over a load)
//   Funct3M         access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   AluResultM      byte address
//   WriteDataM      store data
//   MemReq/MemWe    bus request / write strobe, held for the whole WAIT
//   MemAddr         word-aligned bus address
//   MemWData        store data replicated across the byte lanes
//   MemByteEn       byte-lane enables
//   MemAck          one-cycle bus completion
//   MemRData        read word, valid with MemAck
//   StallM          holds the IF/ID/EX/MEM registers
//   ReadDataM       extended load result, held until the next load completes
//   MisalignM       misaligned access flag (IDLE only, no bus traffic)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | accepting a new M-stage instruction; aligned access stalls
// S_WAIT | bus request outstanding, outputs frozen until MemAck
// S_DONE | result valid, pipeline advances, no new access this cycle
module mem_stage_lsu #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [1:0]       ResultSrcM,
   input  logic             MemWriteM,
   input  logic [2:0]       Funct3M,
   input  logic [WIDTH-1:0] AluResultM,
   input  logic [WIDTH-1:0] WriteDataM,
   output logic             MemReq,
   output logic             MemWe,
   output logic [WIDTH-1:0] MemAddr,
   output logic [WIDTH-1:0] MemWData,
   output logic [3:0]       MemByteEn,
   input  logic             MemAck,
   input  logic [WIDTH-1:0] MemRData,
   output logic             StallM,
   output logic [WIDTH-1:0] ReadDataM,
   output logic             MisalignM
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   logic             is_store;
   logic             access;
   logic             misalign;
   logic             start;
   logic [1:0]       size;
   logic [1:0]       a;
   logic [3:0]       be_nx;
   logic [WIDTH-1:0] wdata_nx;
   logic [1:0]       lat_a;
   logic [2:0]       lat_f3;
   logic [7:0]       rbyte;
   logic [15:0]      rhalf;
   logic [WIDTH-1:0] load_ext;

   // A store wins when both the load and store controls are set.
   assign is_store = MemWriteM;
   assign access   = (ResultSrcM == 2'b01) | MemWriteM;
   assign size     = Funct3M[1:0];
   assign a        = AluResultM[1:0];

   always_comb begin
      misalign = 1'b0;
      case (size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = a[0];
         default: misalign = (a != 2'b00);
      endcase
   end

   always_comb begin
      be_nx    = 4'b1111;
      wdata_nx = WriteDataM;
      if (is_store) begin
         case (size)
            2'b00: begin
               be_nx    = 4'b0001 << a;
               wdata_nx = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
               be_nx    = 4'b0011 << a;
               wdata_nx = {2{WriteDataM[15:0]}};
            end
            default: begin
               be_nx    = 4'b1111;
               wdata_nx = WriteDataM;
            end
         endcase
      end
   end

   // Lane selection uses the address offset latched at request time.
   always_comb begin
      rbyte = MemRData[7:0];
      case (lat_a)
         2'd0: rbyte = MemRData[7:0];
         2'd1: rbyte = MemRData[15:8];
         2'd2: rbyte = MemRData[23:16];
         2'd3: rbyte = MemRData[31:24];
         default: rbyte = MemRData[7:0];
      endcase
      rhalf = lat_a[1] ? MemRData[31:16] : MemRData[15:0];
      case (lat_f3)
         3'b000:  load_ext = {{24{rbyte[7]}}, rbyte};
         3'b001:  load_ext = {{16{rhalf[15]}}, rhalf};
         3'b100:  load_ext = {24'd0, rbyte};
         3'b101:  load_ext = {16'd0, rhalf};
         default: load_ext = MemRData;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      StallM    = 1'b0;
      MisalignM = 1'b0;
      start     = 1'b0;
      case (state)
         S_IDLE: begin
            if (access) begin
               if (misalign) begin
                  MisalignM = 1'b1;
               end else begin
                  StallM   = 1'b1;
                  start    = 1'b1;
                  state_nx = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            StallM = 1'b1;
            if (MemAck) state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      // Flags read as zero while reset is held, whatever the M-stage inputs are.
      if (RST) begin
         StallM    = 1'b0;
         MisalignM = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         MemReq    <= 1'b0;
         MemWe     <= 1'b0;
         MemAddr   <= '0;
         MemWData  <= '0;
         MemByteEn <= 4'b0000;
         ReadDataM <= '0;
         lat_a     <= 2'b00;
         lat_f3    <= 3'b000;
      end else if (start) begin
         MemReq    <= 1'b1;
         MemWe     <= is_store;
         MemAddr   <= {AluResultM[WIDTH-1:2], 2'b00};
         MemWData  <= wdata_nx;
         MemByteEn <= be_nx;
         lat_a     <= a;
         lat_f3    <= Funct3M;
      end else if (state == S_WAIT && MemAck) begin
         MemReq <= 1'b0;
         if (!MemWe) ReadDataM <= load_ext;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] AluResultM;
   logic [31:0] WriteDataM;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [3:0]  MemByteEn;
   logic        MemAck;
   logic [31:0] MemRData;
   logic        StallM;
   logic [31:0] ReadDataM;
   logic        MisalignM;

   int total = 0;
   int bad   = 0;

   mem_stage_lsu #(.WIDTH(32)) dut (
      .CLK(CLK), .RST(RST),
      .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .AluResultM(AluResultM), .WriteDataM(WriteDataM),
      .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemByteEn(MemByteEn), .MemAck(MemAck), .MemRData(MemRData),
      .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM)
   );

   always #5 CLK = ~CLK;

   // Holds one instruction in M until a cycle with StallM=0 has passed, as the
   // pipeline would. ack_at = WAIT cycle (1-based) carrying MemAck; 0 = ack held high.
   // Entry and exit are at posedge+1.
   task automatic run_access(
      input  logic [1:0]  rs, input logic we, input logic [2:0] f3,
      input  logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
      input  int          ack_at,
      output int          cycles, output int stall_n, output int req_n,
      output logic [31:0] addr_o, output logic [31:0] wdata_o,
      output logic [3:0]  be_o, output logic we_o, output logic stable,
      output logic        mis, output logic [31:0] rd_done);
      int  wcnt;
      logic done;
      ResultSrcM = rs; MemWriteM = we; Funct3M = f3;
      AluResultM = addr; WriteDataM = wd; MemRData = rdata;
      cycles = 0; stall_n = 0; req_n = 0; wcnt = 0; done = 1'b0;
      addr_o = '0; wdata_o = '0; be_o = '0; we_o = 1'b0; stable = 1'b1;
      mis = 1'b0; rd_done = '0;
      while (!done && cycles < 40) begin
         if (MemReq) wcnt++;
         MemAck = (ack_at == 0) ? 1'b1 : (MemReq && wcnt == ack_at);
         @(negedge CLK);
         if (StallM) stall_n++;
         if (MisalignM) mis = 1'b1;
         if (MemReq) begin
            if (req_n == 0) begin
               addr_o = MemAddr; wdata_o = MemWData; be_o = MemByteEn; we_o = MemWe;
            end else if (MemAddr !== addr_o || MemWData !== wdata_o ||
                         MemByteEn !== be_o || MemWe !== we_o) begin
               stable = 1'b0;
            end
            req_n++;
         end
         if (!StallM) begin
            done = 1'b1;
            rd_done = ReadDataM;
         end
         @(posedge CLK); #1;
         cycles++;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL access_timeout: addr=%h still stalled after %0d cycles, required completion", addr, cycles);
      end
      ResultSrcM = 2'b00; MemWriteM = 1'b0; MemAck = 1'b0;
   endtask

   int          cyc, stn, rqn;
   logic [31:0] ao, wo, rdo;
   logic [3:0]  beo;
   logic        weo, stb, mso;

   task automatic test_reset();
      RST = 1'b1;
      ResultSrcM = 2'b00; MemWriteM = 1'b0; Funct3M = 3'b000;
      AluResultM = '0; WriteDataM = '0; MemAck = 1'b0; MemRData = '0;
      #1;
      total++;
      if ({MemReq, MemWe, MemAddr, MemWData, MemByteEn, StallM, ReadDataM, MisalignM} !== '0) begin
         bad++;
         $display("FAIL reset_values: req=%b we=%b addr=%h wd=%h be=%b stall=%b rd=%h mis=%b, required all 0",
                  MemReq, MemWe, MemAddr, MemWData, MemByteEn, StallM, ReadDataM, MisalignM);
      end
      ResultSrcM = 2'b01; Funct3M = 3'b010; AluResultM = 32'h100;
      #1;
      total++;
      if (StallM !== 1'b0) begin
         bad++; $display("FAIL reset_stall: got %b, required 0", StallM);
      end
      ResultSrcM = 2'b00;
      @(negedge CLK); RST = 1'b0;
      @(posedge CLK); #1;
      total++;
      if (MemReq !== 1'b0 || StallM !== 1'b0) begin
         bad++; $display("FAIL reset_release: req=%b stall=%b, required 0 0", MemReq, StallM);
      end
   endtask

   task automatic test_lw();
      run_access(2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1,
                 cyc, stn, rqn, ao, wo, beo, weo, stb, mso, rdo);
      total++;
      if (cyc !== 3 || stn !== 2 || rqn !== 1) begin
         bad++; $display("FAIL lw_timing: cycles=%0d stall=%0d req=%0d, required 3 2 1", cyc, stn, rqn);
      end
      total++;
      if (ao !== 32'h100 || beo !== 4'b1111 || weo !== 1'b0) begin
         bad++; $display("FAIL lw_bus: addr=%h be=%b we=%b, required 00000100 1111 0", ao, beo, weo);
      end
      total++;
      if (rdo !== 32'hDEADBEEF) begin
         bad++; $display("FAIL lw_data: got %h, required deadbeef", rdo);
      end
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] ads  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
      logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
      for (int i = 0; i < 4; i++) begin
         run_access(2'b01, 1'b0, f3s[i], ads[i], 32'h0, 32'h80FF0000, 1,
                    cyc, stn, rqn, ao, wo, beo, weo, stb, mso, rdo);
         total++;
         if (rdo !== exps[i] || ao !== 32'h100) begin
            bad++;
            $display("FAIL load_ext[%0d]: data=%h addr=%h, required %h 00000100", i, rdo, ao, exps[i]);
         end
      end
   endtask

   task automatic test_sb_delayed();
      run_access(2'b00, 1'b1, 3'b000, 32'h201, 32'h12345678, 32'h55555555, 3,
                 cyc, stn, rqn, ao, wo, beo, weo, stb, mso, rdo);
      total++;
      if (weo !== 1'b1 || beo !== 4'b0010 || wo !== 32'h78787878 || ao !== 32'h200) begin
         bad++;
         $display("FAIL sb_bus: we=%b be=%b wd=%h addr=%h, required 1 0010 78787878 00000200", weo, beo, wo, ao);
      end
      total++;
      if (stn !== 4 || rqn !== 3 || cyc !== 5) begin
         bad++; $display("FAIL sb_timing: stall=%0d req=%0d cycles=%0d, required 4 3 5", stn, rqn, cyc);
      end
      total++;
      if (stb !== 1'b1) begin
         bad++; $display("FAIL sb_stable: stable=%b, required 1", stb);
      end
      total++;
      if (rdo !== 32'h000080FF) begin
         bad++; $display("FAIL sb_readdata: got %h, required 000080ff", rdo);
      end
   endtask

   task automatic test_sh();
      run_access(2'b00, 1'b1, 3'b001, 32'h102, 32'h12345678, 32'h0, 1,
                 cyc, stn, rqn, ao, wo, beo, weo, stb, mso, rdo);
      total++;
      if (beo !== 4'b1100 || wo !== 32'h56785678 || weo !== 1'b1 || cyc !== 3) begin
         bad++;
         $display("FAIL sh_bus: be=%b wd=%h we=%b cycles=%0d, required 1100 56785678 1 3", beo, wo, weo, cyc);
      end
   endtask

   task automatic test_store_wins();
      run_access(2'b01, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h99999999, 1,
                 cyc, stn, rqn, ao, wo, beo, weo, stb, mso, rdo);
      total++;
      if (weo !== 1'b1 || wo !== 32'hCAFEF00D || beo !== 4'b1111 || rdo !== 32'h000080FF) begin
         bad++;
         $display("FAIL store_wins: we=%b wd=%h be=%b rd=%h, required 1 cafef00d 1111 000080ff", weo, wo, beo, rdo);
      end
   endtask

   task automatic test_misalign();
      logic        wes [3] = '{1'b1, 1'b0, 1'b0};
      logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b010};
      logic [31:0] ads [3] = '{32'h202, 32'h101, 32'h201};
      for (int i = 0; i < 3; i++) begin
         run_access(wes[i] ? 2'b00 : 2'b01, wes[i], f3s[i], ads[i], 32'h11112222, 32'h77777777, 1,
                    cyc, stn, rqn, ao, wo, beo, weo, stb, mso, rdo);
         total++;
         if (mso !== 1'b1 || rqn !== 0 || stn !== 0 || cyc !== 1 || rdo !== 32'h000080FF) begin
            bad++;
            $display("FAIL misalign[%0d]: mis=%b req=%0d stall=%0d cycles=%0d rd=%h, required 1 0 0 1 000080ff",
                     i, mso, rqn, stn, cyc, rdo);
         end
      end
   endtask

   task automatic test_nonmem();
      logic [1:0] rss [2] = '{2'b00, 2'b10};
      for (int i = 0; i < 2; i++) begin
         run_access(rss[i], 1'b0, 3'b010, 32'h202, 32'h0, 32'h0, 1,
                    cyc, stn, rqn, ao, wo, beo, weo, stb, mso, rdo);
         total++;
         if (stn !== 0 || rqn !== 0 || mso !== 1'b0 || cyc !== 1) begin
            bad++;
            $display("FAIL nonmem[%0d]: stall=%0d req=%0d mis=%b cycles=%0d, required 0 0 0 1", i, stn, rqn, mso, cyc);
         end
      end
   endtask

   task automatic test_reset_mid();
      ResultSrcM = 2'b01; MemWriteM = 1'b0; Funct3M = 3'b010;
      AluResultM = 32'h300; MemRData = 32'h11111111; MemAck = 1'b0;
      @(posedge CLK); #1;
      total++;
      if (MemReq !== 1'b1 || StallM !== 1'b1) begin
         bad++; $display("FAIL rstmid_wait: req=%b stall=%b, required 1 1", MemReq, StallM);
      end
      #2 RST = 1'b1;
      #1;
      total++;
      if (MemReq !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
         bad++; $display("FAIL rstmid_drop: req=%b stall=%b rd=%h, required 0 0 0", MemReq, StallM, ReadDataM);
      end
      ResultSrcM = 2'b00;
      @(negedge CLK); RST = 1'b0;
      @(posedge CLK); #1 MemAck = 1'b1;
      @(posedge CLK); #1 MemAck = 1'b0;
      total++;
      if (MemReq !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
         bad++; $display("FAIL rstmid_ack: req=%b stall=%b rd=%h, required 0 0 0", MemReq, StallM, ReadDataM);
      end
      run_access(2'b01, 1'b0, 3'b010, 32'h304, 32'h0, 32'h000000A5, 1,
                 cyc, stn, rqn, ao, wo, beo, weo, stb, mso, rdo);
      total++;
      if (cyc !== 3 || rdo !== 32'h000000A5) begin
         bad++; $display("FAIL rstmid_next: cycles=%0d rd=%h, required 3 000000a5", cyc, rdo);
      end
   endtask

   task automatic test_back_to_back();
      run_access(2'b01, 1'b0, 3'b010, 32'h400, 32'h0, 32'h01020304, 0,
                 cyc, stn, rqn, ao, wo, beo, weo, stb, mso, rdo);
      total++;
      if (cyc !== 3 || stn !== 2 || rdo !== 32'h01020304) begin
         bad++; $display("FAIL b2b_first: cycles=%0d stall=%0d rd=%h, required 3 2 01020304", cyc, stn, rdo);
      end
      run_access(2'b01, 1'b0, 3'b100, 32'h401, 32'h0, 32'hAABBCCDD, 0,
                 cyc, stn, rqn, ao, wo, beo, weo, stb, mso, rdo);
      total++;
      if (cyc !== 3 || stn !== 2 || rdo !== 32'h000000CC) begin
         bad++; $display("FAIL b2b_second: cycles=%0d stall=%0d rd=%h, required 3 2 000000cc", cyc, stn, rdo);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_sb_delayed();
      test_sh();
      test_store_wins();
      test_misalign();
      test_nonmem();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
